divu_seq: RTL and testbench

//  Sequential unsigned 32/32 divider for the MIPS DIVU instruction; inverse of the

---
 rtl/divu_seq.sv | 131 +++++++++++++
 tb/tb_divu_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_seq.sv
// divu_seq: sequential unsigned WIDTH/WIDTH divider (MIPS DIVU).
// Radix-2 restoring division. The divider produces one quotient bit per clock.
// A normal operation keeps busy high for WIDTH cycles. A divide by zero
// completes in a single cycle.
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request; accepted only while not busy (IDLE or DONE)
//   dividend  sampled at the accepting edge only
//   divisor   sampled at the accepting edge only
//   q         quotient (registered, feeds LO)
//   r         remainder (registered, feeds HI)
//   busy      operation in progress
//   done      one-cycle pulse; q/r/dbz valid
//   dbz       divide-by-zero flag for the last result
module divu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_sh;
  logic [CW-1:0]    cnt;

  logic             div_zero;
  logic             last;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // One restoring step. Bring the next dividend bit into the partial
  // remainder, then trial-subtract the divisor. A clear borrow bit means the
  // subtraction fits, so a 1 is shifted into the quotient.
  always_comb begin
    div_zero = (divisor == '0);
    last     = (cnt == CW'(WIDTH - 1));
    t        = {rem_acc, quo_sh[WIDTH-1]};
    diff     = t - {1'b0, dvs_r};
    ge       = ~diff[WIDTH];
    rem_nxt  = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    quo_nxt  = {quo_sh[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = div_zero ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvs_r   <= '0;
      rem_acc <= '0;
      quo_sh  <= '0;
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (div_zero) begin
              // A divisor of zero gives its result immediately, and the
              // divider never becomes busy.
              q    <= '1;
              r    <= dividend;
              dbz  <= 1'b1;
              done <= 1'b1;
            end else begin
              dvs_r   <= divisor;
              rem_acc <= '0;
              quo_sh  <= dividend;
              cnt     <= '0;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_acc <= rem_nxt;
          quo_sh  <= quo_nxt;
          cnt     <= cnt + CW'(1);
          if (last) begin
            q    <= quo_nxt;
            r    <= rem_nxt;
            dbz  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: self-checking bench for divu_seq. The bench compares the DUT
// against plain '/' and '%' arithmetic. It expects a latency of WIDTH edges,
// or zero edges after the accepting edge for a divide by zero.
module tb_divu_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  int n_cmp  = 0;
  int n_fail = 0;

  divu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result, computed from the arithmetic definition.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez, output int ee);
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1; ee = 0;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; ee = W;
    end
  endtask

  // Issue one op and wait for done, with a bounded wait. edge_idx is the
  // number of edges after the accepting edge until done is seen. busy_cyc
  // counts the sampled cycles with busy high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edge_idx, output int busy_cyc);
    dividend = a; divisor = b; start = 1'b1;
    step();
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    edge_idx = 0; busy_cyc = 0;
    while (done !== 1'b1 && edge_idx < 40) begin
      if (busy === 1'b1) busy_cyc++;
      step();
      edge_idx++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    n_cmp++; if (q !== '0)    begin n_fail++; $display("FAIL reset_q: got %h expected 0", q); end
    n_cmp++; if (r !== '0)    begin n_fail++; $display("FAIL reset_r: got %h expected 0", r); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (dbz !== 1'b0)  begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int e, bc;
    run_op(32'd100, 32'd7, e, bc);
    n_cmp++; if (e !== W)  begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", e, W); end
    n_cmp++; if (bc !== W) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
    n_cmp++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d expected 14", q); end
    n_cmp++; if (r !== 32'd2)  begin n_fail++; $display("FAIL basic_r: got %0d expected 2", r); end
    n_cmp++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", dbz); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    repeat (5) step();
    n_cmp++; if (q !== 32'd14 || r !== 32'd2) begin n_fail++; $display("FAIL basic_hold: got q=%0d r=%0d expected q=14 r=2", q, r); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] eq, er;
    logic         ez;
    int           ee, e, bc;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;
    ta[1] = 32'd3;         tb[1] = 32'd10;
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      ref_div(ta[i], tb[i], eq, er, ez, ee);
      run_op(ta[i], tb[i], e, bc);
      n_cmp++; if (q !== eq) begin n_fail++; $display("FAIL directed%0d_q: got %h expected %h", i, q, eq); end
      n_cmp++; if (r !== er) begin n_fail++; $display("FAIL directed%0d_r: got %h expected %h", i, r, er); end
      n_cmp++; if (e !== ee) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, e, ee); end
      step();
    end
  endtask

  task automatic test_divzero();
    int e, bc;
    run_op(32'd5, 32'd0, e, bc);
    n_cmp++; if (e !== 0)  begin n_fail++; $display("FAIL dbz_latency: got %0d expected 0", e); end
    n_cmp++; if (bc !== 0) begin n_fail++; $display("FAIL dbz_busy_cycles: got %0d expected 0", bc); end
    n_cmp++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_q: got %h expected ffffffff", q); end
    n_cmp++; if (r !== 32'd5)  begin n_fail++; $display("FAIL dbz_r: got %h expected 5", r); end
    n_cmp++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dbz_after: got done=%b busy=%b expected 0/0", done, busy); end
    n_cmp++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b expected 1", dbz); end
  endtask

  task automatic test_ignore_start();
    int e;
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    e = 0;
    while (done !== 1'b1 && e < 40) begin
      if (e == 9) begin start = 1'b1; dividend = 32'd9; divisor = 32'd2; end
      step();
      e++;
      start = 1'b0;
    end
    n_cmp++; if (e !== W) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", e, W); end
    n_cmp++; if (q !== 32'd333) begin n_fail++; $display("FAIL ignore_q: got %0d expected 333", q); end
    n_cmp++; if (r !== 32'd1)   begin n_fail++; $display("FAIL ignore_r: got %0d expected 1", r); end
    step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_after: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int e, bc, dones;
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (q !== '0 || r !== '0) begin n_fail++; $display("FAIL midreset_qr: got q=%h r=%h expected 0/0", q, r); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b dbz=%b expected 0", busy, done, dbz); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
    run_op(32'd50, 32'd5, e, bc);
    n_cmp++; if (q !== 32'd10 || r !== 32'd0) begin n_fail++; $display("FAIL midreset_rerun: got q=%0d r=%0d expected q=10 r=0", q, r); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [7];
    logic [W-1:0] b [7];
    logic [W-1:0] eq, er;
    logic         ez;
    int           ee, w, edge_n, prev;
    for (int i = 0; i < 7; i++) begin
      a[i] = $urandom;
      b[i] = (i % 2 == 1) ? W'($urandom) : W'($urandom_range(1, 255));
      if (b[i] == '0) b[i] = 32'd1;
    end
    dividend = a[0]; divisor = b[0]; start = 1'b1;
    step();
    edge_n = 0; prev = -1;
    for (int i = 0; i < 6; i++) begin
      dividend = a[i+1]; divisor = b[i+1];
      w = 0;
      while (done !== 1'b1 && w < 40) begin step(); edge_n++; w++; end
      ref_div(a[i], b[i], eq, er, ez, ee);
      n_cmp++; if (q !== eq || r !== er) begin n_fail++; $display("FAIL b2b%0d_qr: got q=%h r=%h expected q=%h r=%h", i, q, r, eq, er); end
      if (i > 0) begin
        n_cmp++; if (edge_n - prev !== 33) begin n_fail++; $display("FAIL b2b%0d_period: got %0d expected 33", i, edge_n - prev); end
      end
      prev = edge_n;
      step(); edge_n++;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_reaccept: got done=%b busy=%b expected 0/1", i, done, busy); end
    end
    start = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 40) begin step(); w++; end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int           ee, e, bc;
    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 16));
        3:       b = a;
        4:       b = W'($urandom) >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ref_div(a, b, eq, er, ez, ee);
      run_op(a, b, e, bc);
      n_cmp++; if (q !== eq) begin n_fail++; $display("FAIL rand%0d_q: a=%h b=%h got %h expected %h", i, a, b, q, eq); end
      n_cmp++; if (r !== er) begin n_fail++; $display("FAIL rand%0d_r: a=%h b=%h got %h expected %h", i, a, b, r, er); end
      n_cmp++; if (dbz !== ez) begin n_fail++; $display("FAIL rand%0d_dbz: got %b expected %b", i, dbz, ez); end
      n_cmp++; if (e !== ee) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, e, ee); end
    end
    step();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_divzero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
